// File: rtl/frac_clk_synth.sv
// NCH independent fractional-N clock synthesizers running off ref_clk.
// Define FSYN_SYNC_EN to add the sync_req input that re-aligns all active channels.
module frac_clk_synth #(
   parameter int unsigned NCH    = 4,
   parameter int unsigned INT_W  = 8,
   parameter int unsigned FRAC_W = 8,
   localparam int unsigned CHW   = ($clog2(NCH) > 1) ? $clog2(NCH) : 1
) (
   input  logic              ref_clk,
   input  logic              rst_n,
   input  logic              cfg_valid,
   output logic              cfg_ready,
   input  logic [CHW-1:0]    cfg_ch,
   input  logic [INT_W-1:0]  cfg_int,
   input  logic [FRAC_W-1:0] cfg_frac,
   input  logic              cfg_en,
   output logic              cfg_err,
`ifdef FSYN_SYNC_EN
   input  logic              sync_req,
`endif
   output logic [NCH-1:0]    syn_clk,
   output logic [NCH-1:0]    syn_tick,
   output logic [NCH-1:0]    active
);

   logic [NCH-1:0]             active_q, active_d, clk_q, clk_d, tick_q, tick_d;
   logic [NCH-1:0]             pend_q, pend_d, sh_en_q, sh_en_d;
   logic [NCH-1:0][INT_W-1:0]  int_q, int_d, sh_int_q, sh_int_d, cnt_q, cnt_d;
   logic [NCH-1:0][FRAC_W-1:0] frac_q, frac_d, sh_frac_q, sh_frac_d, acc_q, acc_d;
   logic [NCH-1:0][FRAC_W:0]   acc_sum;
   logic [NCH-1:0]             ch_sel;
   logic                       ch_ok, fire, req_bad, cfg_err_q, cfg_err_d, sync_now;

`ifdef FSYN_SYNC_EN
   assign sync_now = sync_req;
`else
   assign sync_now = 1'b0;
`endif

   always_comb begin
      ch_ok = 32'(cfg_ch) < NCH;
      for (int unsigned i = 0; i < NCH; i++) begin
         ch_sel[i]  = (32'(cfg_ch) == i);
         acc_sum[i] = {1'b0, acc_q[i]} + {1'b0, frac_q[i]};
      end
      cfg_ready = ch_ok ? ~|(pend_q & ch_sel) : 1'b1;
      fire      = cfg_valid & cfg_ready;
      req_bad   = !ch_ok || (cfg_en && (cfg_int < INT_W'(2)));
      cfg_err_d = fire & req_bad;
   end

   always_comb begin
      active_d  = active_q;
      clk_d     = clk_q;
      tick_d    = '0;
      pend_d    = pend_q;
      cnt_d     = cnt_q;
      acc_d     = acc_q;
      int_d     = int_q;
      frac_d    = frac_q;
      sh_int_d  = sh_int_q;
      sh_frac_d = sh_frac_q;
      sh_en_d   = sh_en_q;
      for (int unsigned i = 0; i < NCH; i++) begin
         if (active_q[i] && sync_now) begin
            clk_d[i] = 1'b0;
            acc_d[i] = '0;
            cnt_d[i] = int_q[i] - INT_W'(1);
            if (pend_q[i]) begin
               pend_d[i] = 1'b0;
               if (sh_en_q[i]) begin
                  int_d[i]  = sh_int_q[i];
                  frac_d[i] = sh_frac_q[i];
                  cnt_d[i]  = sh_int_q[i] - INT_W'(1);
               end else begin
                  active_d[i] = 1'b0;
                  cnt_d[i]    = '0;
               end
            end
         end else if (active_q[i] && (cnt_q[i] == '0)) begin
            clk_d[i]  = ~clk_q[i];
            tick_d[i] = 1'b1;
            // A pending disable is held back until the edge that takes the clock low.
            if (pend_q[i] && (sh_en_q[i] || clk_q[i])) begin
               pend_d[i] = 1'b0;
               acc_d[i]  = '0;
               if (sh_en_q[i]) begin
                  int_d[i]  = sh_int_q[i];
                  frac_d[i] = sh_frac_q[i];
                  cnt_d[i]  = sh_int_q[i] - INT_W'(1);
               end else begin
                  active_d[i] = 1'b0;
                  clk_d[i]    = 1'b0;
                  cnt_d[i]    = '0;
               end
            end else begin
               acc_d[i] = acc_sum[i][FRAC_W-1:0];
               cnt_d[i] = int_q[i] - INT_W'(1) + INT_W'(acc_sum[i][FRAC_W]);
            end
         end else if (active_q[i]) begin
            cnt_d[i] = cnt_q[i] - INT_W'(1);
         end

         if (fire && !req_bad && ch_sel[i]) begin
            if (!active_q[i]) begin
               if (cfg_en) begin
                  active_d[i] = 1'b1;
                  int_d[i]    = cfg_int;
                  frac_d[i]   = cfg_frac;
                  cnt_d[i]    = cfg_int - INT_W'(1);
                  acc_d[i]    = '0;
                  clk_d[i]    = 1'b0;
               end
            end else begin
               sh_int_d[i]  = cfg_int;
               sh_frac_d[i] = cfg_frac;
               sh_en_d[i]   = cfg_en;
               pend_d[i]    = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge ref_clk or negedge rst_n) begin
      if (!rst_n) begin
         active_q  <= '0;
         clk_q     <= '0;
         tick_q    <= '0;
         pend_q    <= '0;
         sh_en_q   <= '0;
         int_q     <= '0;
         sh_int_q  <= '0;
         cnt_q     <= '0;
         frac_q    <= '0;
         sh_frac_q <= '0;
         acc_q     <= '0;
         cfg_err_q <= 1'b0;
      end else begin
         active_q  <= active_d;
         clk_q     <= clk_d;
         tick_q    <= tick_d;
         pend_q    <= pend_d;
         sh_en_q   <= sh_en_d;
         int_q     <= int_d;
         sh_int_q  <= sh_int_d;
         cnt_q     <= cnt_d;
         frac_q    <= frac_d;
         sh_frac_q <= sh_frac_d;
         acc_q     <= acc_d;
         cfg_err_q <= cfg_err_d;
      end
   end

   assign syn_clk  = clk_q;
   assign syn_tick = tick_q;
   assign active   = active_q;
   assign cfg_err  = cfg_err_q;

endmodule
